// File: rtl/dac_sched_pkg.sv
// Shared types and helpers for the DAC sample scheduler.
package dac_sched_pkg;

    localparam int DAC_W = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SLEW = 1'b1
    } state_t;

    // An out-of-range pointer restarts the search at requester 0.
    function automatic int rr_start(input int ptr, input int nreq);
        return (ptr < nreq) ? ptr : 0;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin search of req starting at ptr; one-hot grant plus its index.
module rr_arbiter
    import dac_sched_pkg::*;
#(
    parameter int NREQ = 2,
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx
);

    int   start;
    int   j;
    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        start = rr_start(int'(ptr), NREQ);
        for (int k = 0; k < NREQ; k++) begin
            j = (start + k) % NREQ;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/dac_sample_sched.sv
// Paced, slew-limited, round-robin scheduler driving the DAC code bus.
// state   | meaning
// ST_IDLE | waiting for a tick to accept the next sample
// ST_SLEW | stepping dac_code toward an accepted target, one step per tick
module dac_sample_sched
    import dac_sched_pkg::*;
#(
    parameter int            NREQ       = 2,
    parameter int            W          = DAC_W,
    parameter int            DIVW       = 16,
    parameter logic [W-1:0]  RESET_CODE = W'(512),
    localparam int           IW         = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              enable,
    input  logic [DIVW-1:0]   div_cfg,
    input  logic [W-1:0]      slew_max,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic [W-1:0]      dac_code,
    output logic              dac_upd,
    output logic              busy,
    output logic [IW-1:0]     grant_id,
    output logic [15:0]       underrun_cnt
);

    state_t          state;
    logic [DIVW-1:0] cnt;
    logic [W-1:0]    target;
    logic [IW-1:0]   rr_ptr;
    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic            tick;
    logic            accept;
    logic [W-1:0]    win_data;
    logic [W-1:0]    step_tgt;
    logic signed [W:0] diff;
    logic [W:0]      mag;
    logic            slew_done;
    logic [W-1:0]    code_step;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    always_comb begin
        tick      = enable && (cnt >= div_cfg);
        accept    = tick && (state == ST_IDLE) && (|arb_gnt);
        req_ready = (tick && (state == ST_IDLE)) ? arb_gnt : '0;
        win_data  = req_data[int'(arb_idx)*W +: W];
        step_tgt  = (state == ST_SLEW) ? target : win_data;
        diff      = $signed({1'b0, step_tgt}) - $signed({1'b0, dac_code});
        mag       = diff[W] ? $unsigned(-diff) : $unsigned(diff);
        slew_done = (slew_max == '0) || (mag <= {1'b0, slew_max});
        // |diff| > slew_max here, so a full step can neither overshoot nor wrap.
        if (slew_done)
            code_step = step_tgt;
        else if (diff[W])
            code_step = dac_code - slew_max;
        else
            code_step = dac_code + slew_max;
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            target       <= RESET_CODE;
            dac_code     <= RESET_CODE;
            rr_ptr       <= '0;
            grant_id     <= '0;
            underrun_cnt <= '0;
            dac_upd      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            dac_upd <= 1'b0;
            if (enable)
                cnt <= tick ? '0 : cnt + 1'b1;
            if (accept || (tick && state == ST_SLEW)) begin
                dac_code <= code_step;
                dac_upd  <= (code_step != dac_code);
                state    <= slew_done ? ST_IDLE : ST_SLEW;
                busy     <= !slew_done;
            end
            if (accept) begin
                target   <= win_data;
                grant_id <= arb_idx;
                rr_ptr   <= (int'(arb_idx) == NREQ - 1) ? '0 : arb_idx + 1'b1;
            end else if (tick && state == ST_IDLE && underrun_cnt != 16'hFFFF) begin
                underrun_cnt <= underrun_cnt + 1'b1;
            end
        end
    end

endmodule
